// File: rtl/shake_input_padder.sv
`default_nettype none
// ============================================================================
// Module   : shake_input_padder
// Brief    : Packs stream words into a rate block and applies SHAKE pad10*1.
// Revision : 1.0
// ============================================================================
module shake_input_padder #(
  parameter int         W          = 64,
  parameter int         RATE_LANES = 21,
  parameter logic [7:0] DOMAIN     = 8'h1F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             data_in,
  input  logic                     valid_in,
  input  logic                     last_in,
  input  logic [3:0]               last_nbytes,
  output logic                     ready_o,
  output logic [RATE_LANES*W-1:0]  block_o,
  output logic                     input_buffer_ready,
  output logic                     last_block_in_input_buffer,
  input  logic                     input_buffer_ready_clr,
  input  logic                     last_block_in_buffer_clr
);

  localparam int c_lane_bytes = W / 8;
  localparam int c_nbytes     = RATE_LANES * c_lane_bytes;
  localparam int c_cw         = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam int c_pw         = $clog2(c_nbytes + 1);

  typedef enum logic [1:0] {
    S_FILL          = 2'd0,
    S_FULL          = 2'd1,
    S_PAD_ONLY      = 2'd2,
    S_WAIT_LAST_CLR = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_cw-1:0]         r_cnt;
  logic                    r_ibr;
  logic                    r_last;
  logic                    r_pad_pending;
  logic [c_nbytes*8-1:0]   r_block;
  logic [c_nbytes*8-1:0]   w_block_next;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_lane_end;
  logic                    w_block_done;
  logic                    w_consume;
  logic                    w_pad_now;
  logic                    w_exact_fill;
  logic [3:0]              w_k;
  logic [c_pw-1:0]         w_p;

  assign w_accept     = valid_in && w_ready;
  assign w_lane_end   = (r_cnt == c_cw'(RATE_LANES - 1));
  assign w_block_done = w_accept && (last_in || w_lane_end);
  assign w_consume    = (r_state == S_FULL) && input_buffer_ready_clr && r_ibr;
  assign w_k          = (last_nbytes > 4'd8) ? 4'd8 : last_nbytes;
  // Absolute byte offset of the first pad byte within the block.
  assign w_p          = (c_pw'(r_cnt) << 3) + c_pw'(w_k);
  assign w_pad_now    = w_accept && last_in && (w_p <  c_pw'(c_nbytes));
  assign w_exact_fill = w_accept && last_in && (w_p == c_pw'(c_nbytes));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      S_FILL: begin
        w_ready = 1'b1;
        if (w_block_done) begin
          w_state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (w_consume) begin
          if (r_pad_pending) begin
            w_state_next = S_PAD_ONLY;
          end else if (r_last && !last_block_in_buffer_clr) begin
            w_state_next = S_WAIT_LAST_CLR;
          end else begin
            w_state_next = S_FILL;
          end
        end
      end
      S_PAD_ONLY: begin
        w_state_next = S_FULL;
      end
      S_WAIT_LAST_CLR: begin
        if (last_block_in_buffer_clr) begin
          w_state_next = S_FILL;
        end
      end
      default: begin
        w_state_next = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_ibr         <= 1'b0;
      r_last        <= 1'b0;
      r_pad_pending <= 1'b0;
    end else begin
      if (w_consume) begin
        r_cnt <= '0;
      end else if (w_accept && !w_block_done) begin
        r_cnt <= r_cnt + c_cw'(1);
      end

      if (w_block_done || (r_state == S_PAD_ONLY)) begin
        r_ibr <= 1'b1;
      end else if (w_consume) begin
        r_ibr <= 1'b0;
      end

      if (w_pad_now || (r_state == S_PAD_ONLY)) begin
        r_last <= 1'b1;
      end else if (last_block_in_buffer_clr) begin
        r_last <= 1'b0;
      end

      if (w_exact_fill) begin
        r_pad_pending <= 1'b1;
      end else if (r_state == S_PAD_ONLY) begin
        r_pad_pending <= 1'b0;
      end
    end
  end

  // Lanes above the write pointer are already zero, so padding is a per-byte
  // overlay applied on the accepting edge.
  for (genvar b = 0; b < c_nbytes; b++) begin : g_byte
    localparam int c_lane = b / c_lane_bytes;
    localparam int c_pos  = b % c_lane_bytes;
    logic [7:0] w_nb;

    always_comb begin
      w_nb = r_block[8*b +: 8];
      if (w_consume) begin
        w_nb = 8'h00;
      end else if (r_state == S_PAD_ONLY) begin
        w_nb = (b == 0) ? DOMAIN : 8'h00;
        if (b == c_nbytes - 1) begin
          w_nb = w_nb | 8'h80;
        end
      end else if (w_accept) begin
        if (r_cnt == c_cw'(c_lane)) begin
          w_nb = (last_in && (4'(c_pos) >= w_k)) ? 8'h00 : data_in[8*c_pos +: 8];
        end
        if (w_pad_now && (w_p == c_pw'(b))) begin
          w_nb = w_nb ^ DOMAIN;
        end
        if (w_pad_now && (b == c_nbytes - 1)) begin
          w_nb = w_nb | 8'h80;
        end
      end
    end

    assign w_block_next[8*b +: 8] = w_nb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_block <= '0;
    end else begin
      r_block <= w_block_next;
    end
  end

  assign ready_o                    = w_ready;
  assign block_o                    = r_block;
  assign input_buffer_ready         = r_ibr;
  assign last_block_in_input_buffer = r_last;

endmodule
`default_nettype wire
